// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared widths, opcode encodings and the EX/MEM record
// for the ThinPad execute stage.
package exe_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    localparam logic [REG_AW-1:0] REG_SP = 4'd8;
    localparam logic [REG_AW-1:0] REG_IH = 4'd9;
    localparam logic [REG_AW-1:0] REG_RA = 4'd10;
    localparam logic [REG_AW-1:0] REG_T  = 4'd11;
    localparam logic [REG_AW-1:0] NOREG  = 4'hF;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_CMP,
        ALU_PASSA, ALU_PASSB, ALU_LINK, ALU_NOP
    } aluop_e;

    typedef enum logic [1:0] {CB_REG, CB_IMM, CB_ZERO, CB_ONE} cb_e;
    typedef enum logic [1:0] {J_B, J_JR, J_BEQZ, J_BNEZ} jorb_e;
    typedef enum logic [1:0] {CM_NONE, CM_LOAD, CM_STORE, CM_RSVD} cm_e;
    typedef enum logic {ST_RUN, ST_SQUASH} state_e;

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic [REG_AW-1:0] wreg;
        logic [1:0]        controlmem;
        logic              controlwb;
    } exmem_t;

    localparam exmem_t EXMEM_BUBBLE = '{
        alu_result: '0, store_data: '0, wreg: NOREG, controlmem: 2'b00, controlwb: 1'b0
    };

    // MEM is the younger producer, so it wins over WB; NOREG is never a real source.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [DATA_W-1:0] rdata,
        input logic [REG_AW-1:0] rreg,
        input logic              mem_wen,
        input logic [REG_AW-1:0] mem_wreg,
        input logic [DATA_W-1:0] mem_wdata,
        input logic              wb_wen,
        input logic [REG_AW-1:0] wb_wreg,
        input logic [DATA_W-1:0] wb_wdata
    );
        return (rreg == NOREG)                   ? rdata     :
               (mem_wen && mem_wreg == rreg)     ? mem_wdata :
               (wb_wen && wb_wreg == rreg)       ? wb_wdata  : rdata;
    endfunction

endpackage

// File: rtl/exe_stage_alu16.sv
// alu16: combinational 16-bit ALU for the execute stage.
module alu16
    import exe_stage_pkg::*;
(
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic [DATA_W-1:0] res_o
);

    // A zero shift field encodes a shift by 8.
    logic [3:0] sh;
    assign sh = {b_i[2:0] == 3'd0, b_i[2:0]};

    always_comb begin
        res_o = '0;
        case (op_i)
            ALU_ADD:   res_o = a_i + b_i;
            ALU_SUB:   res_o = a_i - b_i;
            ALU_AND:   res_o = a_i & b_i;
            ALU_OR:    res_o = a_i | b_i;
            ALU_XOR:   res_o = a_i ^ b_i;
            ALU_NOT:   res_o = ~a_i;
            ALU_SLL:   res_o = a_i << sh;
            ALU_SRL:   res_o = a_i >> sh;
            ALU_SRA:   res_o = $signed(a_i) >>> sh;
            ALU_SLT:   res_o = {15'd0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU:  res_o = {15'd0, a_i < b_i};
            ALU_CMP:   res_o = {15'd0, a_i != b_i};
            ALU_PASSA: res_o = a_i;
            ALU_PASSB: res_o = b_i;
            ALU_LINK:  res_o = pc_i;
            default:   res_o = '0;
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// exe_stage: ThinPad execute stage -- forwarding, ALU, branch resolution and
// the EX/MEM register with stall hold and one-edge post-branch squash.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rdata1_in,
    input  logic [DATA_W-1:0] rdata2_in,
    input  logic [DATA_W-1:0] imme_in,
    input  logic [REG_AW-1:0] wreg_in,
    input  logic [REG_AW-1:0] rreg1_in,
    input  logic [REG_AW-1:0] rreg2_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [3:0]        aluop_in,
    input  logic [1:0]        controlb_in,
    input  logic              ifjump_in,
    input  logic [1:0]        jorb_in,
    input  logic [1:0]        controlmem_in,
    input  logic              controlwb_in,
    input  logic              mem_wen,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] mem_wreg,
    input  logic [REG_AW-1:0] wb_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              stall_in,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [REG_AW-1:0] wreg_out,
    output logic [1:0]        controlmem_out,
    output logic              controlwb_out,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic              flush_out
);

    logic [DATA_W-1:0] fwd_a, fwd_b, op_b, alu_res, target;
    logic              take;
    state_e            state_q, state_d;
    exmem_t            exmem_q, exmem_d;
    logic              taken_q, taken_d;
    logic [DATA_W-1:0] target_q, target_d;

    assign fwd_a = fwd_sel(rdata1_in, rreg1_in, mem_wen, mem_wreg, mem_wdata,
                           wb_wen, wb_wreg, wb_wdata);
    assign fwd_b = fwd_sel(rdata2_in, rreg2_in, mem_wen, mem_wreg, mem_wdata,
                           wb_wen, wb_wreg, wb_wdata);

    assign op_b = (controlb_in == CB_REG)  ? fwd_b   :
                  (controlb_in == CB_IMM)  ? imme_in :
                  (controlb_in == CB_ZERO) ? 16'h0000 : 16'h0001;

    alu16 u_alu (
        .op_i  (aluop_in),
        .a_i   (fwd_a),
        .b_i   (op_b),
        .pc_i  (pc_in),
        .res_o (alu_res)
    );

    assign take = ifjump_in && ((jorb_in == J_B) || (jorb_in == J_JR) ||
                                ((jorb_in == J_BEQZ) && (fwd_a == '0)) ||
                                ((jorb_in == J_BNEZ) && (fwd_a != '0)));
    assign target = (jorb_in == J_JR) ? fwd_a : pc_in + imme_in;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            exmem_q  <= EXMEM_BUBBLE;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            exmem_q  <= exmem_d;
            taken_q  <= taken_d;
            target_q <= target_d;
        end
    end

    // Stall freezes the state so a pending branch resolves on the first free edge.
    always_comb begin
        state_d = stall_in ? state_q :
                  (state_q == ST_SQUASH) ? ST_RUN :
                  take ? ST_SQUASH : ST_RUN;
    end

    always_comb begin
        exmem_d  = stall_in ? exmem_q :
                   (state_q == ST_SQUASH) ? EXMEM_BUBBLE :
                   '{alu_result: alu_res, store_data: fwd_b, wreg: wreg_in,
                     controlmem: controlmem_in, controlwb: controlwb_in};
        taken_d  = !stall_in && (state_q == ST_RUN) && take;
        target_d = taken_d ? target : target_q;
    end

    assign alu_result_out = exmem_q.alu_result;
    assign store_data_out = exmem_q.store_data;
    assign wreg_out       = exmem_q.wreg;
    assign controlmem_out = exmem_q.controlmem;
    assign controlwb_out  = exmem_q.controlwb;
    assign branch_taken   = taken_q;
    assign branch_target  = target_q;
    assign flush_out      = taken_q;

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed self-checking bench for exe_stage.
module tb_exe_stage;

    logic        clk, rst;
    logic [15:0] rdata1_in, rdata2_in, imme_in, pc_in, mem_wdata, wb_wdata;
    logic [3:0]  wreg_in, rreg1_in, rreg2_in, aluop_in, mem_wreg, wb_wreg;
    logic [1:0]  controlb_in, jorb_in, controlmem_in;
    logic        ifjump_in, controlwb_in, mem_wen, wb_wen, stall_in;
    logic [15:0] alu_result_out, store_data_out, branch_target;
    logic [3:0]  wreg_out;
    logic [1:0]  controlmem_out;
    logic        controlwb_out, branch_taken, flush_out;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  cb;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] e;
    } av_t;
    av_t alu_tab [20];

    exe_stage dut (
        .clk(clk), .rst(rst),
        .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imme_in(imme_in),
        .wreg_in(wreg_in), .rreg1_in(rreg1_in), .rreg2_in(rreg2_in),
        .pc_in(pc_in), .aluop_in(aluop_in), .controlb_in(controlb_in),
        .ifjump_in(ifjump_in), .jorb_in(jorb_in), .controlmem_in(controlmem_in),
        .controlwb_in(controlwb_in), .mem_wen(mem_wen), .wb_wen(wb_wen),
        .mem_wreg(mem_wreg), .wb_wreg(wb_wreg), .mem_wdata(mem_wdata),
        .wb_wdata(wb_wdata), .stall_in(stall_in),
        .alu_result_out(alu_result_out), .store_data_out(store_data_out),
        .wreg_out(wreg_out), .controlmem_out(controlmem_out),
        .controlwb_out(controlwb_out), .branch_taken(branch_taken),
        .branch_target(branch_target), .flush_out(flush_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rdata1_in = '0; rdata2_in = '0; imme_in = '0; pc_in = '0;
        wreg_in = 4'hF; rreg1_in = 4'hF; rreg2_in = 4'hF;
        aluop_in = 4'd15; controlb_in = 2'b00; ifjump_in = 1'b0; jorb_in = 2'b00;
        controlmem_in = 2'b00; controlwb_in = 1'b0;
        mem_wen = 1'b0; wb_wen = 1'b0; mem_wreg = 4'hF; wb_wreg = 4'hF;
        mem_wdata = '0; wb_wdata = '0; stall_in = 1'b0;
    endtask

    // Advance one active (falling) edge and sample 1 time unit later.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #1 rst = 1'b0;
        #2;
        vectors++;
        if ({alu_result_out, store_data_out, branch_target} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%h/%h want 0/0/0", alu_result_out, store_data_out, branch_target);
        end
        vectors++;
        if ({wreg_out, controlmem_out, controlwb_out, branch_taken, flush_out} !== {4'hF, 2'b00, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_ctrl: got wreg=%h cm=%b wb=%b bt=%b fl=%b want F/00/0/0/0",
                     wreg_out, controlmem_out, controlwb_out, branch_taken, flush_out);
        end
        #1 rst = 1'b1;
    endtask

    task automatic test_forward();
        idle();
        rreg1_in = 4'd3; rdata1_in = 16'h0005; mem_wen = 1'b1; mem_wreg = 4'd3; mem_wdata = 16'h0010;
        controlb_in = 2'b01; imme_in = 16'h0002; aluop_in = 4'd0; wreg_in = 4'd1; controlwb_in = 1'b1;
        step();
        vectors++;
        if ({alu_result_out, wreg_out, controlwb_out} !== {16'h0012, 4'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL add_mem_fwd: got %h wreg=%h wb=%b want 0012/1/1", alu_result_out, wreg_out, controlwb_out);
        end
        idle();
        aluop_in = 4'd12; rreg1_in = 4'd6; rdata1_in = 16'h0001;
        wb_wen = 1'b1; wb_wreg = 4'd6; wb_wdata = 16'h0100;
        mem_wen = 1'b1; mem_wreg = 4'd7; mem_wdata = 16'hFFFF;
        step();
        vectors++;
        if (alu_result_out !== 16'h0100) begin
            miscompares++;
            $display("FAIL wb_fwd: got %h want 0100", alu_result_out);
        end
        idle();
        aluop_in = 4'd12; rreg1_in = 4'hF; rdata1_in = 16'h0042;
        mem_wen = 1'b1; mem_wreg = 4'hF; mem_wdata = 16'hDEAD;
        step();
        vectors++;
        if (alu_result_out !== 16'h0042) begin
            miscompares++;
            $display("FAIL noreg_fwd: got %h want 0042", alu_result_out);
        end
        idle();
        aluop_in = 4'd12; rreg1_in = 4'd2; rdata1_in = 16'h0033; mem_wreg = 4'd2; mem_wdata = 16'h9999;
        step();
        vectors++;
        if (alu_result_out !== 16'h0033) begin
            miscompares++;
            $display("FAIL wen_off_fwd: got %h want 0033", alu_result_out);
        end
    endtask

    task automatic test_priority();
        idle();
        rreg2_in = 4'd4; rdata2_in = 16'h1234;
        mem_wen = 1'b1; mem_wreg = 4'd4; mem_wdata = 16'hAAAA;
        wb_wen = 1'b1; wb_wreg = 4'd4; wb_wdata = 16'h5555;
        rreg1_in = 4'd0; rdata1_in = 16'h0100; controlb_in = 2'b01; imme_in = 16'h0003;
        aluop_in = 4'd0; controlmem_in = 2'b10;
        step();
        vectors++;
        if ({store_data_out, alu_result_out, controlmem_out} !== {16'hAAAA, 16'h0103, 2'b10}) begin
            miscompares++;
            $display("FAIL mem_over_wb: got sd=%h addr=%h cm=%b want AAAA/0103/10",
                     store_data_out, alu_result_out, controlmem_out);
        end
        idle();
        rreg2_in = 4'd5; rdata2_in = 16'h0007; aluop_in = 4'd1; rreg1_in = 4'd1; rdata1_in = 16'h0009;
        step();
        vectors++;
        if ({store_data_out, alu_result_out} !== {16'h0007, 16'h0002}) begin
            miscompares++;
            $display("FAIL reg_b_sub: got sd=%h res=%h want 0007/0002", store_data_out, alu_result_out);
        end
    endtask

    task automatic test_alu();
        alu_tab = '{
            {4'd0,  2'b01, 16'h7FFF, 16'h0001, 16'h8000},
            {4'd1,  2'b01, 16'h0005, 16'h0007, 16'hFFFE},
            {4'd2,  2'b01, 16'hF0F0, 16'h3C3C, 16'h3030},
            {4'd3,  2'b01, 16'hF0F0, 16'h0F00, 16'hFFF0},
            {4'd4,  2'b01, 16'hA5A5, 16'hFFFF, 16'h5A5A},
            {4'd5,  2'b01, 16'h00FF, 16'h0000, 16'hFF00},
            {4'd6,  2'b01, 16'h0001, 16'h0000, 16'h0100},
            {4'd6,  2'b01, 16'h0001, 16'h000B, 16'h0008},
            {4'd7,  2'b01, 16'h8000, 16'h0008, 16'h0080},
            {4'd8,  2'b01, 16'h8000, 16'h0003, 16'hF000},
            {4'd9,  2'b01, 16'hFFFF, 16'h0001, 16'h0001},
            {4'd10, 2'b01, 16'hFFFF, 16'h0001, 16'h0000},
            {4'd11, 2'b01, 16'h0005, 16'h0005, 16'h0000},
            {4'd11, 2'b01, 16'h0005, 16'h0006, 16'h0001},
            {4'd12, 2'b01, 16'h1234, 16'h0000, 16'h1234},
            {4'd13, 2'b01, 16'h0000, 16'hBEEF, 16'hBEEF},
            {4'd14, 2'b01, 16'h0000, 16'h0000, 16'h1234},
            {4'd15, 2'b01, 16'hFFFF, 16'hFFFF, 16'h0000},
            {4'd0,  2'b11, 16'h0005, 16'hFFFF, 16'h0006},
            {4'd13, 2'b10, 16'h0005, 16'hFFFF, 16'h0000}
        };
        for (int i = 0; i < 20; i++) begin
            idle();
            pc_in = 16'h1234;
            aluop_in = alu_tab[i].op; controlb_in = alu_tab[i].cb;
            rdata1_in = alu_tab[i].a; imme_in = alu_tab[i].b;
            step();
            vectors++;
            if (alu_result_out !== alu_tab[i].e) begin
                miscompares++;
                $display("FAIL alu[%0d] op=%0d: got %h want %h", i, alu_tab[i].op, alu_result_out, alu_tab[i].e);
            end
        end
    endtask

    task automatic test_branch();
        idle();
        ifjump_in = 1'b1; jorb_in = 2'b10; rreg1_in = 4'd5; rdata1_in = 16'h0000;
        pc_in = 16'h0040; imme_in = 16'hFFFC;
        step();
        vectors++;
        if ({branch_taken, flush_out, branch_target} !== {2'b11, 16'h003C}) begin
            miscompares++;
            $display("FAIL beqz_taken: got bt=%b fl=%b tgt=%h want 1/1/003C", branch_taken, flush_out, branch_target);
        end
        idle();
        aluop_in = 4'd0; wreg_in = 4'd2; controlwb_in = 1'b1; rdata1_in = 16'h0001; controlb_in = 2'b11;
        step();
        vectors++;
        if ({controlwb_out, wreg_out, branch_taken, flush_out} !== {1'b0, 4'hF, 2'b00}) begin
            miscompares++;
            $display("FAIL squash_bubble: got wb=%b wreg=%h bt=%b fl=%b want 0/F/0/0",
                     controlwb_out, wreg_out, branch_taken, flush_out);
        end
        step();
        vectors++;
        if ({controlwb_out, wreg_out, alu_result_out} !== {1'b1, 4'd2, 16'h0002}) begin
            miscompares++;
            $display("FAIL after_squash: got wb=%b wreg=%h res=%h want 1/2/0002", controlwb_out, wreg_out, alu_result_out);
        end
        idle();
        ifjump_in = 1'b1; jorb_in = 2'b10; rreg1_in = 4'd11; rdata1_in = 16'h0003;
        aluop_in = 4'd12; wreg_in = 4'd1; controlwb_in = 1'b1;
        step();
        vectors++;
        if ({branch_taken, alu_result_out, wreg_out} !== {1'b0, 16'h0003, 4'd1}) begin
            miscompares++;
            $display("FAIL beqz_not_taken: got bt=%b res=%h wreg=%h want 0/0003/1", branch_taken, alu_result_out, wreg_out);
        end
        idle();
        ifjump_in = 1'b1; jorb_in = 2'b01; rreg1_in = 4'd10; rdata1_in = 16'h1111;
        mem_wen = 1'b1; mem_wreg = 4'd10; mem_wdata = 16'h2468;
        step();
        vectors++;
        if ({branch_taken, branch_target} !== {1'b1, 16'h2468}) begin
            miscompares++;
            $display("FAIL jr_fwd: got bt=%b tgt=%h want 1/2468", branch_taken, branch_target);
        end
        idle();
        step();
    endtask

    task automatic test_stall_branch();
        idle();
        aluop_in = 4'd13; controlb_in = 2'b01; imme_in = 16'h0077; wreg_in = 4'd3; controlwb_in = 1'b1;
        step();
        idle();
        ifjump_in = 1'b1; jorb_in = 2'b11; rreg1_in = 4'd1; rdata1_in = 16'h0007;
        pc_in = 16'h0100; imme_in = 16'h0010; stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({alu_result_out, wreg_out, controlwb_out, branch_taken, flush_out} !== {16'h0077, 4'd3, 1'b1, 2'b00}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got res=%h wreg=%h wb=%b bt=%b want 0077/3/1/0",
                         i, alu_result_out, wreg_out, controlwb_out, branch_taken);
            end
        end
        stall_in = 1'b0;
        step();
        vectors++;
        if ({branch_taken, flush_out, branch_target, wreg_out} !== {2'b11, 16'h0110, 4'hF}) begin
            miscompares++;
            $display("FAIL stall_release: got bt=%b fl=%b tgt=%h wreg=%h want 1/1/0110/F",
                     branch_taken, flush_out, branch_target, wreg_out);
        end
        idle();
        step();
        vectors++;
        if (branch_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pulse: got bt=%b want 0", branch_taken);
        end
        idle();
        ifjump_in = 1'b1; jorb_in = 2'b00; pc_in = 16'h0200; imme_in = 16'h0004;
        aluop_in = 4'd14; wreg_in = 4'd10; controlwb_in = 1'b1;
        step();
        idle();
        stall_in = 1'b1; aluop_in = 4'd0; wreg_in = 4'd2; controlwb_in = 1'b1;
        step();
        vectors++;
        if ({branch_taken, wreg_out, alu_result_out, branch_target} !== {1'b0, 4'd10, 16'h0200, 16'h0204}) begin
            miscompares++;
            $display("FAIL squash_stall: got bt=%b wreg=%h res=%h tgt=%h want 0/A/0200/0204",
                     branch_taken, wreg_out, alu_result_out, branch_target);
        end
        stall_in = 1'b0;
        step();
        vectors++;
        if ({controlwb_out, wreg_out, branch_taken} !== {1'b0, 4'hF, 1'b0}) begin
            miscompares++;
            $display("FAIL squash_after_stall: got wb=%b wreg=%h bt=%b want 0/F/0", controlwb_out, wreg_out, branch_taken);
        end
    endtask

    task automatic test_reset_squash();
        idle();
        ifjump_in = 1'b1; jorb_in = 2'b00; pc_in = 16'h0300; imme_in = 16'h0010;
        aluop_in = 4'd14; wreg_in = 4'd10; controlwb_in = 1'b1;
        step();
        vectors++;
        if ({branch_taken, alu_result_out, branch_target} !== {1'b1, 16'h0300, 16'h0310}) begin
            miscompares++;
            $display("FAIL pre_reset_branch: got bt=%b res=%h tgt=%h want 1/0300/0310", branch_taken, alu_result_out, branch_target);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({alu_result_out, branch_target, wreg_out, controlwb_out, branch_taken, flush_out} !==
            {16'h0, 16'h0, 4'hF, 3'b000}) begin
            miscompares++;
            $display("FAIL async_reset: got res=%h tgt=%h wreg=%h wb=%b bt=%b fl=%b want 0/0/F/0/0/0",
                     alu_result_out, branch_target, wreg_out, controlwb_out, branch_taken, flush_out);
        end
        rst = 1'b1;
        idle();
        aluop_in = 4'd0; rdata1_in = 16'h0005; controlb_in = 2'b01; imme_in = 16'h0001;
        wreg_in = 4'd2; controlwb_in = 1'b1;
        step();
        vectors++;
        if ({alu_result_out, wreg_out, controlwb_out, branch_taken} !== {16'h0006, 4'd2, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL post_reset_add: got res=%h wreg=%h wb=%b bt=%b want 0006/2/1/0",
                     alu_result_out, wreg_out, controlwb_out, branch_taken);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_priority();
        test_alu();
        test_branch();
        test_stall_branch();
        test_reset_squash();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
